// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key position
// and the row/column to hex-code map.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} keypad_state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  localparam int DEBOUNCE_CYCLES_DEF = 48;
  localparam int SCAN_DWELL_DEF      = 3;

  // KEYMAP[row][col]; rows listed 3..0, columns 3..0 within each row ('*'=E, '#'=F)
  localparam logic [3:0][3:0][3:0] KEYMAP = {
    {4'hD, 4'hF, 4'h0, 4'hE},
    {4'hC, 4'h9, 4'h8, 4'h7},
    {4'hB, 4'h6, 4'h5, 4'h4},
    {4'hA, 4'h3, 4'h2, 4'h1}
  };

  function automatic logic [3:0] key_lookup(input key_pos_t p);
    return KEYMAP[p.row][p.col];
  endfunction

  // Lowest-index active-low column; only meaningful when some column is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--)
      if (!cols[i]) idx = 2'(i);
    return idx;
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scan_debouncer_timer.sv
// Saturating stability counter shared by press and release debouncing.
module debounce_timer #(
  parameter int DEBOUNCE_CYCLES = 48
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (clear)            cnt <= '0;
    else if (enable && !done)  cnt <= cnt + CW'(1);
  end

  assign done = (cnt == CW'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/keypad_scan_debouncer.sv
// 4x4 keypad row scanner with press/release debounce; emits one key_valid strobe
// per debounced press and holds key_held until the release is debounced.
module keypad_scan_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SCAN_DWELL      = SCAN_DWELL_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s_cols,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DWELL);

  keypad_state_t state;
  logic [1:0]    row_idx;
  logic [DW-1:0] dwell;
  key_pos_t      sel;

  logic lat_low, dwell_done, tmr_clear, tmr_en, tmr_done;

  assign lat_low    = ~s_cols[sel.col];
  assign dwell_done = (dwell == DW'(SCAN_DWELL - 1));

  // Counter is held clear outside the debounce states so each debounce starts at zero.
  assign tmr_clear = (state == SCAN) || (state == HELD);
  assign tmr_en    = ((state == PRESS_DB) && lat_low) || ((state == RELEASE_DB) && !lat_low);

  debounce_timer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .done   (tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      dwell     <= '0;
      sel       <= '0;
      rows      <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (!dwell_done) begin
            dwell <= dwell + DW'(1);
          end else if (&s_cols) begin
            row_idx <= row_idx + 2'd1;
            rows    <= row_drive(row_idx + 2'd1);
            dwell   <= '0;
          end else begin
            sel   <= '{row: row_idx, col: lowest_low(s_cols)};
            dwell <= '0;
            state <= PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (!lat_low) begin
            dwell <= '0;
            state <= SCAN;
          end else if (tmr_done) begin
            key_code  <= key_lookup(sel);
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end
        end
        HELD: begin
          if (!lat_low) state <= RELEASE_DB;
        end
        RELEASE_DB: begin
          // A low sample here is contact bounce: back to HELD without a new event.
          if (lat_low) begin
            state <= HELD;
          end else if (tmr_done) begin
            key_held <= 1'b0;
            row_idx  <= 2'd0;
            rows     <= 4'b1110;
            dwell    <= '0;
            state    <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_debouncer.sv
// Scoreboarded bench: a physical keypad model drives s_cols from rows, expected key
// events (code, cycle after reset release) are queued and matched on key_valid.
module tb_keypad_scan_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] s_cols, rows, key_code;
  logic       key_valid, key_held;

  logic [3:0][3:0] press;   // press[row][col]
  int cyc;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [3:0] code; int at; } ev_t;
  ev_t sb[$];

  always #5 clk = ~clk;

  keypad_scan_debouncer #(.DEBOUNCE_CYCLES(4), .SCAN_DWELL(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_cols    (s_cols),
    .rows      (rows),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Column goes low when a pressed key sits on a driven (low) row.
  always_comb begin
    s_cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && press[r][c]) s_cols[c] = 1'b0;
  end

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (reset === 1'b1 && key_valid === 1'b1) begin
      if (sb.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("valid_code", key_code, e.code);
        chk("valid_cycle", cyc, e.at);
      end
    end
  end

  function automatic logic [3:0] row_exp(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((k / 3) % 4));
  endfunction

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0][3:0] p);
    @(negedge clk);
    reset = 1'b0;
    press = p;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  logic [3:0][3:0] p;

  initial begin
    reset = 1'b0;
    press = '0;

    // Idle scan after reset
    do_reset('0);
    chk("rst_rows", rows, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    for (int k = 0; k <= 15; k++) begin
      goto(k);
      chk("idle_rows", rows, row_exp(k));
    end
    chk("idle_code", key_code, 4'h0);

    // Solid '5': row1 sampled at edge 6, strobe 4 cycles later
    p = '0; p[1][1] = 1'b1;
    sb.push_back('{4'h5, 10});
    do_reset(p);
    goto(11);
    chk("five_held", key_held, 1'b1);
    chk("five_rows", rows, 4'b1101);
    goto(20);
    chk("five_rows_frozen", rows, 4'b1101);
    chk("five_sb", sb.size(), 0);

    // '#' with bounce before settling
    do_reset('0);
    sb.push_back('{4'hF, 20});
    goto(11); press[3][2] = 1'b1;
    goto(12); press[3][2] = 1'b0;
    goto(13); press[3][2] = 1'b1;
    goto(14); press[3][2] = 1'b0;
    goto(15); press[3][2] = 1'b1;
    goto(19);
    chk("hash_pending", sb.size(), 1);
    goto(22);
    chk("hash_sb", sb.size(), 0);
    chk("hash_held", key_held, 1'b1);

    // '9' with a release glitch, then a clean release
    p = '0; p[2][2] = 1'b1;
    sb.push_back('{4'h9, 13});
    do_reset(p);
    goto(16); press = '0;
    goto(18); press[2][2] = 1'b1;
    chk("nine_held_glitch", key_held, 1'b1);
    goto(20);
    chk("nine_rows_frozen", rows, 4'b1011);
    goto(25); press = '0;
    goto(29);
    chk("nine_held_late", key_held, 1'b1);
    goto(30);
    chk("nine_released", key_held, 1'b0);
    chk("nine_rows_restart", rows, 4'b1110);
    goto(33);
    chk("nine_rows_next", rows, 4'b1101);
    chk("nine_sb", sb.size(), 0);

    // '1' held, 'A' and '7' pressed meanwhile, then '0'
    p = '0; p[0][0] = 1'b1;
    sb.push_back('{4'h1, 7});
    do_reset(p);
    goto(9); press[0][3] = 1'b1; press[2][0] = 1'b1;
    goto(14);
    chk("one_code_kept", key_code, 4'h1);
    chk("one_held", key_held, 1'b1);
    goto(15); press = '0;
    sb.push_back('{4'h0, 36});
    goto(20);
    chk("one_released", key_held, 1'b0);
    press[3][1] = 1'b1;
    goto(38);
    chk("zero_sb", sb.size(), 0);
    chk("zero_code", key_code, 4'h0);

    // Reset during PRESS_DB of 'C'
    p = '0; p[1][1] = 1'b1;
    sb.push_back('{4'h5, 10});
    do_reset(p);
    goto(12); press = '0;
    goto(17); press[2][3] = 1'b1;
    goto(28);
    chk("c_pre_code", key_code, 4'h5);
    chk("c_pre_rows", rows, 4'b1011);
    reset = 1'b0;
    #1;
    chk("c_rst_rows", rows, 4'b1110);
    chk("c_rst_code", key_code, 4'h0);
    chk("c_rst_valid", key_valid, 1'b0);
    chk("c_rst_held", key_held, 1'b0);
    sb.push_back('{4'hC, 13});
    repeat (2) @(negedge clk);
    reset = 1'b1;
    goto(15);
    chk("c_sb", sb.size(), 0);
    chk("c_code", key_code, 4'hC);
    chk("c_held", key_held, 1'b1);

    goto(20);
    chk("sb_final", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
